test_signature_misr: RTL and testbench

Downstream result compactor for the test-project template. It consumes the registered `out_data` stream of the device under test and compresses a fixed number of samples into a multiple-input signature register (MISR). It then reports a stable signature and a done flag for on-chip or SignalTap readback. Its own outputs are registered, so timing analysis of the feeding stage stays valid.

---
 rtl/test_sig_pkg.sv | 41 ++++
 rtl/test_signature_misr_misr_reg.sv | 43 ++++
 rtl/test_signature_misr.sv | 141 ++++++++++++++
 tb/tb_test_signature_misr.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/test_sig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_sig_pkg
// Description : Shared types and the MISR update function for the
//               test-signature compactor.
// Revision    : 1.0 - initial release
// ============================================================================
package test_sig_pkg;

  // Widest signature supported by misr_next.
  localparam int unsigned MISR_MAX_W = 64;

  // Run-control states of the compactor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sig_state_t;

  // One MISR step: shift left, fold the polynomial in when the MSB falls
  // out, then mix the new sample. Operands are carried at full 64-bit
  // width and the result is masked down to 'width' bits, so one function
  // serves every configured width.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           width = MISR_MAX_W
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] fb;
    logic                  msb;
    // width[5:0]-1 wraps to 63 for width 64, which is the intended MSB.
    msb  = sig[width[5:0] - 6'd1];
    fb   = msb ? poly : '0;
    mask = {MISR_MAX_W{1'b1}} >> (7'd64 - width[6:0]);
    return ((sig << 1) ^ fb ^ data) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/test_signature_misr_misr_reg.sv
`default_nettype none
// ============================================================================
// Module      : misr_reg
// Description : WIDTH-bit multiple-input signature register with a SEED
//               load and an accept enable.
// Revision    : 1.0 - initial release
// ============================================================================
module misr_reg
  import test_sig_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h04C11DB7),
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_sig_next;

  assign w_sig_next = WIDTH'(misr_next(MISR_MAX_W'(r_sig), MISR_MAX_W'(data),
                                       MISR_MAX_W'(POLY), WIDTH));

  // Signature register: reset and load take the seed, enable folds in data.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_sig <= SEED;
    end else if (load) begin
      r_sig <= SEED;
    end else if (en) begin
      r_sig <= w_sig_next;
    end
  end

  assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/test_signature_misr.sv
`default_nettype none
// ============================================================================
// Module      : test_signature_misr
// Description : Compacts SAMPLES accepted input words into a MISR signature
//               and reports busy/done; all outputs are registered.
//               Optional build macro TEST_SIG_COMPARE_EN adds the exp_sig
//               input and a registered match output.
// Revision    : 1.0 - initial release
// ============================================================================
module test_signature_misr
  import test_sig_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               SAMPLES = 1024,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(32'h04C11DB7),
  parameter logic [WIDTH-1:0] SEED    = '1
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             signature,
  output logic [$clog2(SAMPLES+1)-1:0] sample_cnt
`ifdef TEST_SIG_COMPARE_EN
  ,
  input  logic [WIDTH-1:0]             exp_sig,
  output logic                         match
`endif
);

  localparam int                c_cnt_w = $clog2(SAMPLES + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SAMPLES - 1);

  sig_state_t         r_state;
  sig_state_t         w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sig;

  // A start on the same edge as a valid sample wins; the sample is dropped.
  assign w_accept = (r_state == RUN) && in_valid && !start;

  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (clk),
    .nrst (nrst),
    .load (start),
    .en   (w_accept),
    .data (in_data),
    .sig  (w_sig)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start always (re)enters RUN; the final accept ends it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (start) begin
          w_state_next = RUN;
        end else if (w_accept && (r_cnt == c_last)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Accepted-sample counter; it stops at SAMPLES because RUN ends there.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Status flags registered from the next state so they line up with the
  // signature register update.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == RUN);
      r_done <= (w_state_next == DONE);
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign signature  = w_sig;
  assign sample_cnt = r_cnt;

`ifdef TEST_SIG_COMPARE_EN
  logic r_match;

  // Registered compare, live every cycle spent in DONE and cleared on exit.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_match <= 1'b0;
    end else begin
      r_match <= (r_state == DONE) && !start && (w_sig == exp_sig);
    end
  end

  assign match = r_match;
`endif

endmodule
`default_nettype wire

// File: tb/tb_test_signature_misr.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_signature_misr
// Description : Self-checking bench for test_signature_misr (WIDTH=8,
//               SAMPLES=4, POLY=8'h1D), two instances seeded FF and 00.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_signature_misr;

  localparam int         W = 8;
  localparam int         N = 4;
  localparam logic [7:0] P = 8'h1D;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] exp_sig = 8'h00;

  logic       busy_a, done_a, busy_b, done_b;
  logic [7:0] sig_a, sig_b;
  logic [2:0] cnt_a, cnt_b;
`ifdef TEST_SIG_COMPARE_EN
  logic       match_a, match_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_phase;          // 0 idle, 1 running, 2 finished
  int unsigned m_sig [2];
  int          m_cnt;
  bit          m_match [2];
  int unsigned m_seed [2] = '{255, 0};

  always #5 clk = ~clk;

  test_signature_misr #(.WIDTH(W), .SAMPLES(N), .POLY(P), .SEED(8'hFF)) dut_a (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .busy       (busy_a),
    .done       (done_a),
    .signature  (sig_a),
    .sample_cnt (cnt_a)
`ifdef TEST_SIG_COMPARE_EN
    ,
    .exp_sig    (exp_sig),
    .match      (match_a)
`endif
  );

  test_signature_misr #(.WIDTH(W), .SAMPLES(N), .POLY(P), .SEED(8'h00)) dut_b (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .busy       (busy_b),
    .done       (done_b),
    .signature  (sig_b),
    .sample_cnt (cnt_b)
`ifdef TEST_SIG_COMPARE_EN
    ,
    .exp_sig    (exp_sig),
    .match      (match_b)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signature step in plain arithmetic: doubling modulo 256, polynomial
  // added when the top bit overflows, then the sample XOR-ed in.
  function automatic int unsigned ref_step(input int unsigned s, input int unsigned d);
    int unsigned t;
    t = (s * 2) % 256;
    if (s >= 128) t = t ^ P;
    return t ^ d;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++)
      m_match[k] = nrst && !start && (m_phase == 2) && (m_sig[k] == exp_sig);
    if (!nrst || start) begin
      m_phase = nrst ? 1 : 0;
      m_cnt   = 0;
      for (int k = 0; k < 2; k++) m_sig[k] = m_seed[k];
    end else if (m_phase == 1 && in_valid) begin
      for (int k = 0; k < 2; k++) m_sig[k] = ref_step(m_sig[k], in_data);
      m_cnt++;
      if (m_cnt == N) m_phase = 2;
    end
  endtask

  task automatic check_all();
    chk("sig_a",  sig_a,  m_sig[0]);
    chk("sig_b",  sig_b,  m_sig[1]);
    chk("cnt_a",  cnt_a,  m_cnt);
    chk("cnt_b",  cnt_b,  m_cnt);
    chk("busy_a", busy_a, m_phase == 1);
    chk("done_a", done_a, m_phase == 2);
    chk("busy_b", busy_b, m_phase == 1);
    chk("done_b", done_b, m_phase == 2);
`ifdef TEST_SIG_COMPARE_EN
    chk("match_a", match_a, m_match[0]);
    chk("match_b", match_b, m_match[1]);
`endif
  endtask

  // One clock: drive inputs, take the edge, sample 1ns later, check.
  task automatic step(input bit s, input bit v, input logic [7:0] d);
    start    = s;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge();
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check_all();
  endtask

  initial begin
    logic [7:0] s1_vec [5];
    s1_vec = '{8'hFF, 8'hE3, 8'hDB, 8'hAB, 8'h4B};
    m_phase = 0;
    m_cnt   = 0;
    for (int k = 0; k < 2; k++) begin
      m_sig[k]   = m_seed[k];
      m_match[k] = 1'b0;
    end

    // Reset state
    nrst = 1'b0;
    step(0, 0, 8'h00);
    step(0, 1, 8'h12);
    chk("rst_sig", sig_a, 8'hFF);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    nrst = 1'b1;

    // Scenario 1: four zero samples back-to-back
    step(1, 0, 8'h00);
    chk("s1_busy_rise", busy_a, 1);
    chk("s1_sig0", sig_a, s1_vec[0]);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 8'h00);
      chk($sformatf("s1_sig%0d", i), sig_a, s1_vec[i]);
    end
    chk("s1_done", done_a, 1);
    chk("s1_cnt", cnt_a, 4);
    chk("s1_busy_fall", busy_a, 0);
    // Inputs in DONE are ignored; compare follows exp_sig with 1-cycle delay
    exp_sig = 8'h4B;
    step(0, 1, 8'h77);
    chk("s1_frozen", sig_a, 8'h4B);
`ifdef TEST_SIG_COMPARE_EN
    chk("s1_match_hi", match_a, 1);
`endif
    exp_sig = 8'h4C;
    step(0, 0, 8'h00);
`ifdef TEST_SIG_COMPARE_EN
    chk("s1_match_lo", match_a, 0);
`endif
    step(0, 0, 8'h00);
    chk("s1_done_hold", done_a, 1);

    // Scenario 2: seed-00 instance, samples 01,00,00,00 with 2-cycle gaps
    step(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, (i == 0) ? 8'h01 : 8'h00);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          step(0, 0, 8'hFF);
          chk("s2_gap_busy", busy_b, 1);
        end
      end
    end
    chk("s2_sig", sig_b, 8'h08);
    chk("s2_done", done_b, 1);

    // Scenario 3: restart after two samples
    step(1, 0, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(1, 0, 8'h00);
    chk("s3_reload", sig_a, 8'hFF);
    chk("s3_cnt0", cnt_a, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
    chk("s3_sig", sig_a, 8'h4B);

    // Scenario 4: start together with a valid sample drops the sample
    step(1, 0, 8'h00);
    step(0, 1, 8'h33);
    step(1, 1, 8'h55);
    chk("s4_sig", sig_a, 8'hFF);
    chk("s4_cnt", cnt_a, 0);

    // Scenario 5: reset mid-run, later samples ignored until start
    step(0, 1, 8'h00);
    nrst = 1'b0;
    step(0, 1, 8'h00);
    nrst = 1'b1;
    chk("s5_sig", sig_a, 8'hFF);
    chk("s5_busy", busy_a, 0);
    step(0, 1, 8'hAA);
    step(0, 1, 8'hAA);
    chk("s5_ignored_sig", sig_a, 8'hFF);
    chk("s5_ignored_cnt", cnt_a, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      nrst    = ($urandom_range(0, 59) != 0);
      exp_sig = ($urandom_range(0, 1) == 0) ? 8'(m_sig[0]) : 8'($urandom);
      step($urandom_range(0, 14) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
